// File: rtl/mfcc_pkg.sv
// Shared constants, state encoding and tag layout for the MFCC log-unit arbiter.
// Also holds the operand zero-substitution helper used on the issue path.
package mfcc_pkg;

    localparam int DW        = 41;
    localparam int OW        = 18;
    localparam int N_VEC     = 24;
    localparam int IW        = 5;
    localparam int TAG_DEPTH = 16;

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_VEC - 1);
    localparam logic [IW-1:0] N_VEC_CNT = IW'(N_VEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VEC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          is_scl;
        logic [IW-1:0] idx;
    } tag_t;

    // log10(0) is undefined, so a zero operand is presented to the unit as 1
    function automatic logic [DW-1:0] nz_operand(input logic [DW-1:0] op);
        if (op == {DW{1'b0}}) begin
            nz_operand = {{(DW-1){1'b0}}, 1'b1};
        end else begin
            nz_operand = op;
        end
    endfunction

endpackage

// File: rtl/mfcc_log_arbiter_tag_fifo.sv
// Synchronous tag FIFO with occupancy counter; push and pop may occur together.
// Read data is the head entry, valid whenever the FIFO is not empty.
module tag_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/mfcc_log_arbiter.sv
// Shares one LOG10 unit between the mel-vector burst path and the scalar VAD path.
// Every issue pushes a tag; in-order results pop the tag and are routed back.
module mfcc_log_arbiter
    import mfcc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          vec_start,
    output logic [IW-1:0] vec_idx,
    input  logic [DW-1:0] vec_data,
    output logic          vec_busy,
    output logic          vec_wr_en,
    output logic [IW-1:0] vec_wr_addr,
    output logic [OW-1:0] vec_wr_data,
    output logic          vec_done,
    input  logic          scl_req,
    input  logic [DW-1:0] scl_data,
    output logic          scl_ack,
    output logic          scl_res_vld,
    output logic [OW-1:0] scl_res,
    output logic          log_i_en,
    output logic [DW-1:0] log_din,
    input  logic          log_o_en,
    input  logic [OW-1:0] log_dout,
    output logic          err
);

    state_t        state_r, state_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [IW-1:0] res_cnt_r, res_cnt_s;
    logic          pending_r, pending_s;
    logic          last_scl_r, last_scl_s;
    logic          err_r;
    logic          can_issue_s;
    logic          issue_s;
    logic          issue_scl_s;
    logic          done_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    tag_t          push_tag_s;
    tag_t          pop_tag_s;
    logic [$bits(tag_t)-1:0] pop_bits_s;

    tag_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_s),
        .wdata (push_tag_s),
        .pop   (pop_s),
        .rdata (pop_bits_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign pop_tag_s   = pop_bits_s;
    assign can_issue_s = !fifo_full_s && !rst;
    assign pop_s       = log_o_en && !fifo_empty_s && !rst;

    // Issue selection, burst sequencing and pending-start handling
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        pending_s   = pending_r;
        last_scl_s  = last_scl_r;
        issue_s     = 1'b0;
        issue_scl_s = 1'b0;
        done_s      = 1'b0;
        if (pop_s && !pop_tag_s.is_scl) begin
            res_cnt_s = res_cnt_r + 1'b1;
        end else begin
            res_cnt_s = res_cnt_r;
        end

        case (state_r)
            IDLE: begin
                if (scl_req) begin
                    issue_s     = can_issue_s;
                    issue_scl_s = can_issue_s;
                    if (vec_start) begin
                        pending_s = 1'b1;
                    end else begin
                        pending_s = pending_r;
                    end
                end else if (vec_start || pending_r) begin
                    state_s   = VEC;
                    idx_s     = {IW{1'b0}};
                    pending_s = 1'b0;
                    res_cnt_s = {IW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            VEC: begin
                if (vec_start) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (can_issue_s) begin
                    issue_s = 1'b1;
                    // strict alternation: never two scalars in a row while a burst runs
                    if (scl_req && !last_scl_r) begin
                        issue_scl_s = 1'b1;
                    end else if (idx_r == LAST_IDX) begin
                        state_s = DRAIN;
                        idx_s   = {IW{1'b0}};
                    end else begin
                        idx_s = idx_r + 1'b1;
                    end
                end else begin
                    issue_s = 1'b0;
                end
            end
            DRAIN: begin
                if (vec_start) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (scl_req && can_issue_s) begin
                    issue_s     = 1'b1;
                    issue_scl_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
                if (res_cnt_r == N_VEC_CNT) begin
                    done_s = 1'b1;
                    if (pending_s) begin
                        state_s   = VEC;
                        idx_s     = {IW{1'b0}};
                        pending_s = 1'b0;
                        res_cnt_s = {IW{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (issue_s) begin
            last_scl_s = issue_scl_s;
        end else begin
            last_scl_s = last_scl_r;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= {IW{1'b0}};
            res_cnt_r  <= {IW{1'b0}};
            pending_r  <= 1'b0;
            last_scl_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            res_cnt_r  <= res_cnt_s;
            pending_r  <= pending_s;
            last_scl_r <= last_scl_s;
        end
    end

    // Sticky flag for a result arriving with no tag outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (log_o_en && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign push_tag_s.is_scl = issue_scl_s;
    assign push_tag_s.idx    = issue_scl_s ? {IW{1'b0}} : idx_r;

    assign vec_idx     = idx_r;
    assign vec_busy    = (state_r != IDLE);
    assign vec_done    = done_s && !rst;
    assign scl_ack     = issue_scl_s;
    assign log_i_en    = issue_s;
    assign log_din     = issue_s ? nz_operand(issue_scl_s ? scl_data : vec_data) : {DW{1'b0}};
    assign vec_wr_en   = pop_s && !pop_tag_s.is_scl;
    assign vec_wr_addr = vec_wr_en ? pop_tag_s.idx : {IW{1'b0}};
    assign vec_wr_data = vec_wr_en ? log_dout : {OW{1'b0}};
    assign scl_res_vld = pop_s && pop_tag_s.is_scl;
    assign scl_res     = scl_res_vld ? log_dout : {OW{1'b0}};
    assign err         = err_r;

endmodule

// File: tb/tb_mfcc_log_arbiter.sv
// Directed self-checking bench for mfcc_log_arbiter with a fixed-latency log unit model.
// Each scenario task drives stimulus and compares against hand-derived cycle/value expectations.
module tb_mfcc_log_arbiter;
    import mfcc_pkg::*;

    logic          clk = 1'b0;
    logic          rst, vec_start, scl_req, log_o_en, err;
    logic [IW-1:0] vec_idx, vec_wr_addr;
    logic [DW-1:0] vec_data, scl_data, log_din;
    logic          vec_busy, vec_wr_en, vec_done, scl_ack, scl_res_vld, log_i_en;
    logic [OW-1:0] vec_wr_data, scl_res, log_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 8;
    logic          flush, stray, zero5;
    logic [OW-1:0] stray_d;
    logic          pv [32];
    logic [OW-1:0] pd [32];

    int            iss_cyc[$], wr_cyc[$], sr_cyc[$], done_cyc[$];
    logic          iss_scl[$];
    logic [DW-1:0] iss_din[$];
    logic [IW-1:0] wr_addr[$];
    logic [OW-1:0] wr_data[$], sr_data[$];
    logic [6:0]    last_outs;
    logic [IW-1:0] last_idx;
    logic [DW-1:0] last_din;
    logic          last_ack, last_busy;

    mfcc_log_arbiter dut (
        .clk(clk), .rst(rst), .vec_start(vec_start), .vec_idx(vec_idx), .vec_data(vec_data),
        .vec_busy(vec_busy), .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
        .vec_wr_data(vec_wr_data), .vec_done(vec_done), .scl_req(scl_req), .scl_data(scl_data),
        .scl_ack(scl_ack), .scl_res_vld(scl_res_vld), .scl_res(scl_res), .log_i_en(log_i_en),
        .log_din(log_din), .log_o_en(log_o_en), .log_dout(log_dout), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] flog(input logic [DW-1:0] x);
        return x[OW-1:0] ^ 18'h15555;
    endfunction

    always_comb vec_data = (zero5 && vec_idx == 5'd5) ? {DW{1'b0}} : DW'(vec_idx) + 41'd100;

    // log unit model: fixed-latency pipeline, cleared by flush
    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 32; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else begin
            for (int i = 31; i > 0; i--) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
            pv[0] <= log_i_en;
            pd[0] <= flog(log_din);
        end
    end
    assign log_o_en = pv[lat-1] | stray;
    assign log_dout = stray ? stray_d : pd[lat-1];

    task automatic observe();
        cyc++;
        last_outs = {vec_busy, vec_wr_en, vec_done, scl_ack, scl_res_vld, log_i_en, err};
        last_idx = vec_idx; last_din = log_din; last_ack = scl_ack; last_busy = vec_busy;
        if (log_i_en) begin iss_cyc.push_back(cyc); iss_scl.push_back(scl_ack); iss_din.push_back(log_din); end
        if (vec_wr_en) begin wr_cyc.push_back(cyc); wr_addr.push_back(vec_wr_addr); wr_data.push_back(vec_wr_data); end
        if (scl_res_vld) begin sr_cyc.push_back(cyc); sr_data.push_back(scl_res); end
        if (vec_done) done_cyc.push_back(cyc);
    endtask

    task automatic next_cyc();
        @(negedge clk); observe(); @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        iss_cyc.delete(); iss_scl.delete(); iss_din.delete(); wr_cyc.delete(); wr_addr.delete();
        wr_data.delete(); sr_cyc.delete(); sr_data.delete(); done_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cyc();
    endtask

    task automatic run_burst(output int c0);
        int n;
        clear_obs();
        c0 = cyc + 1;
        vec_start = 1'b1; next_cyc(); vec_start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 200) begin next_cyc(); n++; end
        next_cyc();
        checks++;
        if (done_cyc.size() != 1) begin errors++; $display("FAIL burst_done_count got=%0d want=1", done_cyc.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; vec_start = 1'b0; scl_req = 1'b0; scl_data = '0;
        stray = 1'b0; stray_d = '0; zero5 = 1'b0;
        idle(3);
        checks++;
        if (last_outs !== 7'b0) begin errors++; $display("FAIL reset_flags got=%b want=0", last_outs); end
        checks++;
        if (last_idx !== '0 || last_din !== '0) begin errors++; $display("FAIL reset_buses idx=%0d din=%0d want=0", last_idx, last_din); end
        rst = 1'b0; flush = 1'b0;
        idle(2);
    endtask

    task automatic test_single_burst();
        int c0;
        run_burst(c0);
        checks++;
        if (iss_cyc.size() != 24 || iss_cyc[0] != c0 + 1 || iss_cyc[23] != c0 + 24) begin
            errors++; $display("FAIL burst_issue n=%0d first=%0d last=%0d want 24,%0d,%0d", iss_cyc.size(), iss_cyc[0], iss_cyc[23], c0 + 1, c0 + 24);
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (iss_din[i] !== DW'(100 + i) || iss_scl[i] !== 1'b0) begin errors++; $display("FAIL burst_din[%0d] got=%0d want=%0d", i, iss_din[i], 100 + i); end
            checks++;
            if (wr_addr[i] !== IW'(i) || wr_data[i] !== flog(DW'(100 + i)) || wr_cyc[i] != c0 + 9 + i) begin
                errors++; $display("FAIL burst_wr[%0d] addr=%0d data=%h cyc=%0d want %0d,%h,%0d", i, wr_addr[i], wr_data[i], wr_cyc[i], i, flog(DW'(100 + i)), c0 + 9 + i);
            end
        end
        checks++;
        if (done_cyc[0] != c0 + 33) begin errors++; $display("FAIL burst_done_cyc got=%0d want=%0d", done_cyc[0], c0 + 33); end
        checks++;
        if (last_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_after got=%b want=0", last_busy); end
    endtask

    task automatic test_scalar_idle();
        int c, n;
        clear_obs();
        c = cyc + 1;
        scl_req = 1'b1; scl_data = 41'd5000; next_cyc(); scl_req = 1'b0;
        checks++;
        if (last_ack !== 1'b1 || last_din !== 41'd5000) begin errors++; $display("FAIL scl_issue ack=%b din=%0d want 1,5000", last_ack, last_din); end
        n = 0;
        while (sr_cyc.size() == 0 && n < 40) begin next_cyc(); n++; end
        checks++;
        if (sr_cyc.size() != 1 || sr_cyc[0] != c + 8 || sr_data[0] !== flog(41'd5000)) begin
            errors++; $display("FAIL scl_result n=%0d cyc=%0d data=%h want 1,%0d,%h", sr_cyc.size(), sr_cyc[0], sr_data[0], c + 8, flog(41'd5000));
        end
        checks++;
        if (wr_cyc.size() != 0) begin errors++; $display("FAIL scl_no_vec_wr got=%0d want=0", wr_cyc.size()); end
    endtask

    task automatic test_contention();
        int c0, n, acks, vi, si;
        logic exp_scl;
        clear_obs();
        c0 = cyc + 1; acks = 0;
        vec_start = 1'b1; next_cyc(); vec_start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && n < 150) begin
            scl_req = (acks < 3); scl_data = DW'(7000 + acks);
            next_cyc();
            if (last_ack) acks++;
            n++;
        end
        scl_req = 1'b0;
        checks++;
        if (iss_cyc.size() != 27 || iss_cyc[26] != c0 + 27) begin errors++; $display("FAIL cont_issue n=%0d last=%0d want 27,%0d", iss_cyc.size(), iss_cyc[26], c0 + 27); end
        vi = 0; si = 0;
        for (int i = 0; i < 27; i++) begin
            exp_scl = (i == 1 || i == 3 || i == 5);
            checks++;
            if (iss_scl[i] !== exp_scl || iss_din[i] !== (exp_scl ? DW'(7000 + si) : DW'(100 + vi))) begin
                errors++; $display("FAIL cont_order[%0d] scl=%b din=%0d want %b,%0d", i, iss_scl[i], iss_din[i], exp_scl, exp_scl ? 7000 + si : 100 + vi);
            end
            if (exp_scl) si++; else vi++;
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (sr_data[j] !== flog(DW'(7000 + j)) || sr_cyc[j] != c0 + 10 + 2 * j) begin
                errors++; $display("FAIL cont_scl_res[%0d] data=%h cyc=%0d want %h,%0d", j, sr_data[j], sr_cyc[j], flog(DW'(7000 + j)), c0 + 10 + 2 * j);
            end
        end
        checks++;
        if (wr_cyc.size() != 24 || wr_addr[23] !== 5'd23 || wr_data[23] !== flog(41'd123) || wr_addr[3] !== 5'd3) begin
            errors++; $display("FAIL cont_wr n=%0d addr23=%0d addr3=%0d", wr_cyc.size(), wr_addr[23], wr_addr[3]);
        end
        checks++;
        if (done_cyc[0] != c0 + 36) begin errors++; $display("FAIL cont_done got=%0d want=%0d", done_cyc[0], c0 + 36); end
    endtask

    task automatic test_zero_operand();
        int c0;
        zero5 = 1'b1;
        run_burst(c0);
        zero5 = 1'b0;
        checks++;
        if (iss_din[5] !== 41'd1 || iss_din[4] !== 41'd104) begin errors++; $display("FAIL zero_sub din5=%0d din4=%0d want 1,104", iss_din[5], iss_din[4]); end
        checks++;
        if (wr_data[5] !== flog(41'd1)) begin errors++; $display("FAIL zero_wr got=%h want=%h", wr_data[5], flog(41'd1)); end
    endtask

    task automatic test_backpressure();
        int c0;
        idle(34);
        lat = 20;
        run_burst(c0);
        checks++;
        if (iss_cyc.size() != 24 || iss_cyc[15] != c0 + 16 || iss_cyc[16] != c0 + 22 || iss_cyc[23] != c0 + 29) begin
            errors++; $display("FAIL bp_issue n=%0d i15=%0d i16=%0d i23=%0d want 24,%0d,%0d,%0d", iss_cyc.size(), iss_cyc[15], iss_cyc[16], iss_cyc[23], c0 + 16, c0 + 22, c0 + 29);
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (wr_addr[i] !== IW'(i) || wr_data[i] !== flog(DW'(100 + i))) begin errors++; $display("FAIL bp_wr[%0d] addr=%0d data=%h", i, wr_addr[i], wr_data[i]); end
        end
        checks++;
        if (wr_cyc[0] != c0 + 21 || done_cyc[0] != c0 + 50 || wr_cyc.size() != 24) begin
            errors++; $display("FAIL bp_timing wr0=%0d done=%0d want %0d,%0d", wr_cyc[0], done_cyc[0], c0 + 21, c0 + 50);
        end
        idle(34);
        lat = 8;
    endtask

    task automatic test_back_to_back();
        int c0, n;
        clear_obs();
        c0 = cyc + 1;
        vec_start = 1'b1; next_cyc();
        n = 1;
        while (done_cyc.size() < 2 && n < 250) begin
            vec_start = (n == 3 || n == 5); next_cyc(); n++;
        end
        vec_start = 1'b0;
        idle(40);
        checks++;
        if (done_cyc.size() != 2 || iss_cyc.size() != 48 || wr_cyc.size() != 48) begin
            errors++; $display("FAIL b2b_count done=%0d iss=%0d wr=%0d want 2,48,48", done_cyc.size(), iss_cyc.size(), wr_cyc.size());
        end
        checks++;
        if (done_cyc[0] != c0 + 33 || iss_cyc[24] != c0 + 34 || done_cyc[1] != c0 + 66) begin
            errors++; $display("FAIL b2b_timing d0=%0d i24=%0d d1=%0d want %0d,%0d,%0d", done_cyc[0], iss_cyc[24], done_cyc[1], c0 + 33, c0 + 34, c0 + 66);
        end
        checks++;
        if (wr_addr[24] !== 5'd0 || wr_addr[47] !== 5'd23) begin errors++; $display("FAIL b2b_addr a24=%0d a47=%0d want 0,23", wr_addr[24], wr_addr[47]); end
    endtask

    task automatic test_reset_mid_burst();
        clear_obs();
        vec_start = 1'b1; next_cyc(); vec_start = 1'b0;
        idle(5);
        rst = 1'b1; flush = 1'b1; next_cyc();
        rst = 1'b0; flush = 1'b0; next_cyc();
        checks++;
        if (last_outs !== 7'b0 || last_idx !== '0 || last_din !== '0) begin
            errors++; $display("FAIL midrst_outputs flags=%b idx=%0d din=%0d want 0", last_outs, last_idx, last_din);
        end
        stray = 1'b1; stray_d = 18'h3; next_cyc(); stray = 1'b0;
        checks++;
        if (last_outs[5] !== 1'b0 || last_outs[2] !== 1'b0 || last_outs[0] !== 1'b0) begin
            errors++; $display("FAIL stray_route flags=%b want wr/res/err=0", last_outs);
        end
        idle(3);
        checks++;
        if (last_outs[0] !== 1'b1) begin errors++; $display("FAIL stray_err got=%b want=1", last_outs[0]); end
        rst = 1'b1; next_cyc(); rst = 1'b0; next_cyc();
        checks++;
        if (last_outs[0] !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", last_outs[0]); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_scalar_idle();
        test_contention();
        test_zero_operand();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
